// File: rtl/dfe_coef_sequencer.sv
// Configuration sequencer for the parallel DFE: fetches coefficients from RAM,
// resets and loads the DFE, waits for done_wait, then gates the sample stream.
module dfe_coef_sequencer #(
    parameter int PULSE_RESPONSE_LENGTH = 5,
    parameter int SIGNAL_RESOLUTION     = 8,
    parameter int COEF_AW               = 8,
    parameter int DFE_RST_CYCLES        = 2,
    parameter int DONE_TIMEOUT          = 64
) (
    input  logic                         clk,
    input  logic                         rstn,
    input  logic                         i_start,
    input  logic [COEF_AW-1:0]           i_coef_base,
    output logic [COEF_AW-1:0]           o_coef_addr,
    output logic                         o_coef_rd,
    input  logic [63:0]                  i_coef_rdata,
    output logic                         o_dfe_rstn,
    output logic                         o_load_mem,
    output logic [7:0]                   o_location,
    output logic [63:0]                  o_mem_data,
    input  logic                         i_done_wait,
    input  logic [SIGNAL_RESOLUTION-1:0] i_s_data,
    input  logic                         i_s_valid,
    output logic                         o_s_ready,
    output logic [SIGNAL_RESOLUTION-1:0] o_dfe_signal_in,
    output logic                         o_dfe_signal_in_valid,
    output logic                         o_running,
    output logic                         o_fault
);

    localparam int PRL = PULSE_RESPONSE_LENGTH;
    localparam int BW  = (PRL > 1) ? $clog2(PRL) : 1;
    localparam int IW  = BW + 1;
    localparam int RW  = (DFE_RST_CYCLES > 1) ? $clog2(DFE_RST_CYCLES) : 1;
    localparam int TW  = $clog2(DONE_TIMEOUT + 1);

    localparam logic [BW-1:0] LAST_IDX   = BW'(PRL - 1);
    localparam logic [IW-1:0] LAST_IDX_W = IW'(PRL - 1);
    localparam logic [IW-1:0] LAST_BEAT  = IW'(PRL + 1);
    localparam logic [RW-1:0] RST_LAST   = RW'(DFE_RST_CYCLES - 1);
    // The timer is 0 in the first WAIT_DONE cycle; firing at DONE_TIMEOUT-2 makes
    // fault visible exactly DONE_TIMEOUT cycles after the last load beat.
    localparam logic [TW-1:0] TIMER_LAST = TW'(DONE_TIMEOUT - 2);

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_DFE_RST   = 3'd1;
    localparam logic [2:0] S_FETCH     = 3'd2;
    localparam logic [2:0] S_LOAD      = 3'd3;
    localparam logic [2:0] S_WAIT_DONE = 3'd4;
    localparam logic [2:0] S_RUN       = 3'd5;
    localparam logic [2:0] S_FAULT     = 3'd6;

    logic [2:0]         r_state;
    logic [COEF_AW-1:0] r_base;
    logic [RW-1:0]      r_rstCnt;
    logic [BW-1:0]      r_rdIdx;
    logic [BW-1:0]      r_capIdx;
    logic               r_rdValid;
    logic [IW-1:0]      r_beat;
    logic [TW-1:0]      r_timer;
    logic [63:0]        r_buf [PRL];

    logic [COEF_AW-1:0] r_coef_addr;
    logic               r_coef_rd;
    logic               r_dfe_rstn;
    logic               r_load_mem;
    logic [7:0]         r_location;
    logic [63:0]        r_mem_data;
    logic               r_s_ready;
    logic               r_running;
    logic               r_fault;

    logic [IW-1:0]      w_nextBeat;
    logic [IW-1:0]      w_nextLoc;
    logic [BW-1:0]      w_nextBufIdx;

    // Beat j presents location min(j, PRL-1) and data buf[clamp(j-1, 0, PRL-1)].
    assign w_nextBeat   = r_beat + IW'(1);
    assign w_nextLoc    = (w_nextBeat > LAST_IDX_W) ? LAST_IDX_W : w_nextBeat;
    assign w_nextBufIdx = (r_beat > LAST_IDX_W) ? LAST_IDX : r_beat[BW-1:0];

    always_ff @(posedge clk) begin
        if (r_state == S_FETCH && r_rdValid) begin
            r_buf[r_capIdx] <= i_coef_rdata;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state     <= S_IDLE;
            r_base      <= '0;
            r_rstCnt    <= '0;
            r_rdIdx     <= '0;
            r_capIdx    <= '0;
            r_rdValid   <= 1'b0;
            r_beat      <= '0;
            r_timer     <= '0;
            r_coef_addr <= '0;
            r_coef_rd   <= 1'b0;
            r_dfe_rstn  <= 1'b0;
            r_load_mem  <= 1'b0;
            r_location  <= '0;
            r_mem_data  <= '0;
            r_s_ready   <= 1'b0;
            r_running   <= 1'b0;
            r_fault     <= 1'b0;
        end else if (i_start) begin
            r_state    <= S_DFE_RST;
            r_base     <= i_coef_base;
            r_rstCnt   <= '0;
            r_rdValid  <= 1'b0;
            r_coef_rd  <= 1'b0;
            r_dfe_rstn <= 1'b0;
            r_load_mem <= 1'b0;
            r_location <= '0;
            r_mem_data <= '0;
            r_s_ready  <= 1'b0;
            r_running  <= 1'b0;
            r_fault    <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_dfe_rstn <= 1'b1;
                end
                S_DFE_RST: begin
                    if (r_rstCnt == RST_LAST) begin
                        r_dfe_rstn  <= 1'b1;
                        r_state     <= S_FETCH;
                        r_coef_rd   <= 1'b1;
                        r_coef_addr <= r_base;
                        r_rdIdx     <= '0;
                        r_capIdx    <= '0;
                    end else begin
                        r_rstCnt <= r_rstCnt + RW'(1);
                    end
                end
                S_FETCH: begin
                    r_rdValid <= r_coef_rd;
                    if (r_coef_rd) begin
                        if (r_rdIdx == LAST_IDX) begin
                            r_coef_rd <= 1'b0;
                        end else begin
                            r_coef_addr <= r_coef_addr + COEF_AW'(1);
                            r_rdIdx     <= r_rdIdx + BW'(1);
                        end
                    end
                    // Final word lands in the buffer on this edge; beat 0 only needs buf[0].
                    if (r_rdValid) begin
                        r_capIdx <= r_capIdx + BW'(1);
                        if (r_capIdx == LAST_IDX) begin
                            r_state    <= S_LOAD;
                            r_load_mem <= 1'b1;
                            r_location <= '0;
                            r_mem_data <= r_buf[0];
                            r_beat     <= '0;
                        end
                    end
                end
                S_LOAD: begin
                    if (r_beat == LAST_BEAT) begin
                        r_load_mem <= 1'b0;
                        r_location <= '0;
                        r_mem_data <= '0;
                        r_timer    <= '0;
                        r_state    <= S_WAIT_DONE;
                    end else begin
                        r_beat     <= w_nextBeat;
                        r_location <= 8'(w_nextLoc);
                        r_mem_data <= r_buf[w_nextBufIdx];
                    end
                end
                S_WAIT_DONE: begin
                    if (i_done_wait) begin
                        r_state   <= S_RUN;
                        r_s_ready <= 1'b1;
                        r_running <= 1'b1;
                    end else if (r_timer == TIMER_LAST) begin
                        r_state <= S_FAULT;
                        r_fault <= 1'b1;
                    end else begin
                        r_timer <= r_timer + TW'(1);
                    end
                end
                S_RUN, S_FAULT: begin
                    r_state <= r_state;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign o_coef_addr           = r_coef_addr;
    assign o_coef_rd             = r_coef_rd;
    assign o_dfe_rstn            = r_dfe_rstn;
    assign o_load_mem            = r_load_mem;
    assign o_location            = r_location;
    assign o_mem_data            = r_mem_data;
    assign o_s_ready             = r_s_ready;
    assign o_running             = r_running;
    assign o_fault               = r_fault;
    assign o_dfe_signal_in       = i_s_data;
    assign o_dfe_signal_in_valid = i_s_valid & r_s_ready;

endmodule

// File: tb/tb_dfe_coef_sequencer.sv
// Directed bench for dfe_coef_sequencer with a behavioural coefficient RAM and
// DFE load-port model; expected values come from hand-built tables.
module tb_dfe_coef_sequencer;

    localparam int PRL = 5;
    localparam int SR  = 8;
    localparam int AW  = 8;
    localparam int DRC = 2;
    localparam int DT  = 64;

    typedef struct {
        int         cyc;
        logic       dfeRstn;
        logic       coefRd;
        logic [7:0] addrOff;
        logic       loadMem;
        logic [7:0] loc;
        logic [7:0] bufIdx;
        logic       sReady;
    } timeRec_t;

    typedef struct {
        logic [7:0] sData;
        logic       sValid;
        logic [7:0] expSig;
        logic       expValid;
    } streamRec_t;

    logic          clk = 1'b0;
    logic          rstn = 1'b0;
    logic          start = 1'b0;
    logic [AW-1:0] coefBase = '0;
    logic [AW-1:0] coefAddr;
    logic          coefRd;
    logic [63:0]   coefRdata = '0;
    logic          dfeRstn;
    logic          loadMem;
    logic [7:0]    location;
    logic [63:0]   memData;
    logic          doneWait;
    logic [SR-1:0] sData = '0;
    logic          sValid = 1'b0;
    logic          sReady;
    logic [SR-1:0] sigIn;
    logic          sigValid;
    logic          running;
    logic          fault;

    int checks = 0;
    int failures = 0;
    int cycNow = 0;
    int overlapCnt = 0;

    timeRec_t   timeline [17];
    streamRec_t streamVec [4];
    logic [7:0] wrapAddrs [5];
    logic [7:0] rdAddrs [16];

    logic        doneEnable = 1'b1;
    logic [63:0] dfeMem [256];
    int          dfeBeats = 0;
    logic [7:0]  dfePrevLoc = '0;

    dfe_coef_sequencer #(
        .PULSE_RESPONSE_LENGTH(PRL),
        .SIGNAL_RESOLUTION(SR),
        .COEF_AW(AW),
        .DFE_RST_CYCLES(DRC),
        .DONE_TIMEOUT(DT)
    ) dut (
        .clk(clk),
        .rstn(rstn),
        .i_start(start),
        .i_coef_base(coefBase),
        .o_coef_addr(coefAddr),
        .o_coef_rd(coefRd),
        .i_coef_rdata(coefRdata),
        .o_dfe_rstn(dfeRstn),
        .o_load_mem(loadMem),
        .o_location(location),
        .o_mem_data(memData),
        .i_done_wait(doneWait),
        .i_s_data(sData),
        .i_s_valid(sValid),
        .o_s_ready(sReady),
        .o_dfe_signal_in(sigIn),
        .o_dfe_signal_in_valid(sigValid),
        .o_running(running),
        .o_fault(fault)
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] ramWord(input logic [7:0] a);
        return {24'hC0EF00, a, ~a, a ^ 8'h3C, 16'h1234};
    endfunction

    // Synchronous RAM; garbage when not read so a mistimed capture shows up.
    always @(posedge clk) begin
        coefRdata <= coefRd ? ramWord(coefAddr) : 64'hBAD0_BAD0_BAD0_BAD0;
    end

    // DFE load port: writes data at the previous beat's location, done after PRL+2 beats.
    always @(posedge clk) begin
        if (!dfeRstn) begin
            dfeBeats <= 0;
        end else if (loadMem) begin
            if (dfeBeats > 0) dfeMem[dfePrevLoc] <= memData;
            dfePrevLoc <= location;
            dfeBeats   <= dfeBeats + 1;
        end
    end
    assign doneWait = doneEnable && (dfeBeats >= PRL + 2);

    always @(posedge clk) cycNow <= cycNow + 1;

    always @(negedge clk) begin
        if (loadMem && sigValid) overlapCnt <= overlapCnt + 1;
    end

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog actual=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=%h required=%h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic [7:0] base);
        @(posedge clk);
        #1;
        start    = 1'b1;
        coefBase = base;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic waitRunning(input int limit, input string name);
        int n = 0;
        while (!running && n < limit) begin
            @(posedge clk);
            #1;
            n++;
        end
        checkOutput(name, 64'(running), 64'(1));
    endtask

    task automatic checkDfe(input logic [7:0] base, input string tag);
        for (int k = 0; k < PRL; k++) begin
            checkOutput($sformatf("%s.pr%0d", tag, k), dfeMem[8'(k)], ramWord(8'(base + 8'(k))));
        end
    endtask

    task automatic runTimeline(input logic [7:0] base);
        for (int i = 0; i < 17; i++) begin
            @(negedge clk);
            checkOutput($sformatf("c%0d.dfeRstn", timeline[i].cyc), 64'(dfeRstn), 64'(timeline[i].dfeRstn));
            checkOutput($sformatf("c%0d.coefRd", timeline[i].cyc), 64'(coefRd), 64'(timeline[i].coefRd));
            checkOutput($sformatf("c%0d.sReady", timeline[i].cyc), 64'(sReady), 64'(timeline[i].sReady));
            checkOutput($sformatf("c%0d.sigValid", timeline[i].cyc), 64'(sigValid), 64'(timeline[i].sReady));
            checkOutput($sformatf("c%0d.loadMem", timeline[i].cyc), 64'(loadMem), 64'(timeline[i].loadMem));
            if (timeline[i].coefRd) begin
                checkOutput($sformatf("c%0d.coefAddr", timeline[i].cyc), 64'(coefAddr),
                            64'(8'(base + timeline[i].addrOff)));
            end
            if (timeline[i].loadMem) begin
                checkOutput($sformatf("c%0d.location", timeline[i].cyc), 64'(location), 64'(timeline[i].loc));
                checkOutput($sformatf("c%0d.memData", timeline[i].cyc), memData,
                            ramWord(8'(base + timeline[i].bufIdx)));
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic runStream(input string tag);
        for (int i = 0; i < 4; i++) begin
            sData  = streamVec[i].sData;
            sValid = streamVec[i].sValid;
            @(negedge clk);
            checkOutput($sformatf("%s.s%0d.sig", tag, i), 64'(sigIn), 64'(streamVec[i].expSig));
            checkOutput($sformatf("%s.s%0d.valid", tag, i), 64'(sigValid), 64'(streamVec[i].expValid));
            @(posedge clk);
            #1;
        end
        sValid = 1'b1;
    endtask

    initial begin
        int n;
        int lowCnt;
        int nRd;
        int lastBeat;
        int faultCyc;
        int readyCnt;

        timeline[0]  = '{1,  1'b0, 1'b0, 8'd0, 1'b0, 8'd0, 8'd0, 1'b0};
        timeline[1]  = '{2,  1'b0, 1'b0, 8'd0, 1'b0, 8'd0, 8'd0, 1'b0};
        timeline[2]  = '{3,  1'b1, 1'b1, 8'd0, 1'b0, 8'd0, 8'd0, 1'b0};
        timeline[3]  = '{4,  1'b1, 1'b1, 8'd1, 1'b0, 8'd0, 8'd0, 1'b0};
        timeline[4]  = '{5,  1'b1, 1'b1, 8'd2, 1'b0, 8'd0, 8'd0, 1'b0};
        timeline[5]  = '{6,  1'b1, 1'b1, 8'd3, 1'b0, 8'd0, 8'd0, 1'b0};
        timeline[6]  = '{7,  1'b1, 1'b1, 8'd4, 1'b0, 8'd0, 8'd0, 1'b0};
        timeline[7]  = '{8,  1'b1, 1'b0, 8'd0, 1'b0, 8'd0, 8'd0, 1'b0};
        timeline[8]  = '{9,  1'b1, 1'b0, 8'd0, 1'b1, 8'd0, 8'd0, 1'b0};
        timeline[9]  = '{10, 1'b1, 1'b0, 8'd0, 1'b1, 8'd1, 8'd0, 1'b0};
        timeline[10] = '{11, 1'b1, 1'b0, 8'd0, 1'b1, 8'd2, 8'd1, 1'b0};
        timeline[11] = '{12, 1'b1, 1'b0, 8'd0, 1'b1, 8'd3, 8'd2, 1'b0};
        timeline[12] = '{13, 1'b1, 1'b0, 8'd0, 1'b1, 8'd4, 8'd3, 1'b0};
        timeline[13] = '{14, 1'b1, 1'b0, 8'd0, 1'b1, 8'd4, 8'd4, 1'b0};
        timeline[14] = '{15, 1'b1, 1'b0, 8'd0, 1'b1, 8'd4, 8'd4, 1'b0};
        timeline[15] = '{16, 1'b1, 1'b0, 8'd0, 1'b0, 8'd0, 8'd0, 1'b0};
        timeline[16] = '{17, 1'b1, 1'b0, 8'd0, 1'b0, 8'd0, 8'd0, 1'b1};

        streamVec[0] = '{8'h12, 1'b1, 8'h12, 1'b1};
        streamVec[1] = '{8'h34, 1'b0, 8'h34, 1'b0};
        streamVec[2] = '{8'hA5, 1'b1, 8'hA5, 1'b1};
        streamVec[3] = '{8'hFF, 1'b1, 8'hFF, 1'b1};

        wrapAddrs[0] = 8'hFE;
        wrapAddrs[1] = 8'hFF;
        wrapAddrs[2] = 8'h00;
        wrapAddrs[3] = 8'h01;
        wrapAddrs[4] = 8'h02;

        // Reset values while rstn is held low.
        #2;
        checkOutput("rst.dfeRstn", 64'(dfeRstn), 64'(0));
        checkOutput("rst.coefRd", 64'(coefRd), 64'(0));
        checkOutput("rst.coefAddr", 64'(coefAddr), 64'(0));
        checkOutput("rst.loadMem", 64'(loadMem), 64'(0));
        checkOutput("rst.location", 64'(location), 64'(0));
        checkOutput("rst.memData", memData, 64'(0));
        checkOutput("rst.sReady", 64'(sReady), 64'(0));
        checkOutput("rst.running", 64'(running), 64'(0));
        checkOutput("rst.fault", 64'(fault), 64'(0));
        #20;
        rstn = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("rel.dfeRstn", 64'(dfeRstn), 64'(1));
        checkOutput("rel.running", 64'(running), 64'(0));

        // Nominal configuration with the sample source always valid.
        sValid = 1'b1;
        sData  = 8'h3C;
        applyStimulus(8'h10);
        runTimeline(8'h10);
        checkOutput("nom.running", 64'(running), 64'(1));
        checkDfe(8'h10, "nom");
        runStream("nomStream");

        // Reconfigure from RUN with a wrapping base address.
        start    = 1'b1;
        coefBase = 8'hFE;
        sData    = 8'h5C;
        @(negedge clk);
        checkOutput("reconf.fwdValid", 64'(sigValid), 64'(1));
        checkOutput("reconf.fwdData", 64'(sigIn), 64'(8'h5C));
        @(posedge clk);
        #1;
        start = 1'b0;
        @(negedge clk);
        checkOutput("reconf.sReadyDrop", 64'(sReady), 64'(0));
        lowCnt = 0;
        nRd = 0;
        n = 0;
        while (!running && n < 300) begin
            if (!dfeRstn) lowCnt++;
            if (coefRd) begin
                if (nRd < 16) rdAddrs[nRd] = coefAddr;
                nRd++;
            end
            @(negedge clk);
            n++;
        end
        checkOutput("reconf.running", 64'(running), 64'(1));
        checkOutput("reconf.rstPulse", 64'(lowCnt), 64'(DRC));
        checkOutput("reconf.numReads", 64'(nRd), 64'(PRL));
        for (int k = 0; k < PRL; k++) begin
            checkOutput($sformatf("wrap.addr%0d", k), 64'(rdAddrs[k]), 64'(wrapAddrs[k]));
        end
        checkDfe(8'hFE, "wrap");
        @(posedge clk);
        #1;
        runStream("reconfStream");

        // Timeout: the DFE never raises done_wait.
        doneEnable = 1'b0;
        applyStimulus(8'h20);
        lastBeat = -1;
        faultCyc = -1;
        readyCnt = 0;
        n = 0;
        while (!fault && n < 300) begin
            @(negedge clk);
            if (loadMem) lastBeat = cycNow;
            if (sReady) readyCnt++;
            if (fault) faultCyc = cycNow;
            n++;
        end
        checkOutput("tmo.fault", 64'(fault), 64'(1));
        checkOutput("tmo.delay", 64'(faultCyc - lastBeat), 64'(DT));
        checkOutput("tmo.noReady", 64'(readyCnt), 64'(0));
        repeat (5) @(posedge clk);
        #1;
        checkOutput("tmo.faultHeld", 64'(fault), 64'(1));
        checkOutput("tmo.sReadyLow", 64'(sReady), 64'(0));
        doneEnable = 1'b1;
        applyStimulus(8'h30);
        @(negedge clk);
        checkOutput("tmo.faultCleared", 64'(fault), 64'(0));
        @(posedge clk);
        #1;
        waitRunning(100, "tmo.recover");
        checkDfe(8'h30, "tmoRecover");

        // Restart during load beat 3.
        applyStimulus(8'h80);
        n = 0;
        while (!(loadMem && location == 8'd3) && n < 100) begin
            @(negedge clk);
            n++;
        end
        checkOutput("midLoad.beat3", 64'(loadMem), 64'(1));
        start    = 1'b1;
        coefBase = 8'h40;
        @(posedge clk);
        #1;
        start = 1'b0;
        @(negedge clk);
        checkOutput("midLoad.abort", 64'(loadMem), 64'(0));
        checkOutput("midLoad.dfeRstn", 64'(dfeRstn), 64'(0));
        @(posedge clk);
        #1;
        waitRunning(100, "midLoad.running");
        checkDfe(8'h40, "midLoad");

        // Asynchronous reset while fetching.
        applyStimulus(8'h50);
        n = 0;
        while (!coefRd && n < 20) begin
            @(negedge clk);
            n++;
        end
        checkOutput("arst.inFetch", 64'(coefRd), 64'(1));
        @(posedge clk);
        #3;
        rstn = 1'b0;
        #1;
        checkOutput("arst.dfeRstn", 64'(dfeRstn), 64'(0));
        checkOutput("arst.coefRd", 64'(coefRd), 64'(0));
        checkOutput("arst.coefAddr", 64'(coefAddr), 64'(0));
        checkOutput("arst.loadMem", 64'(loadMem), 64'(0));
        checkOutput("arst.location", 64'(location), 64'(0));
        checkOutput("arst.memData", memData, 64'(0));
        checkOutput("arst.sReady", 64'(sReady), 64'(0));
        checkOutput("arst.running", 64'(running), 64'(0));
        checkOutput("arst.fault", 64'(fault), 64'(0));
        repeat (3) @(posedge clk);
        #3;
        rstn = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("arst.relDfeRstn", 64'(dfeRstn), 64'(1));
        applyStimulus(8'h60);
        waitRunning(100, "arst.running");
        checkDfe(8'h60, "arst");

        checkOutput("noValidDuringLoad", 64'(overlapCnt), 64'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/dfe_coef_sequencer.md
# dfe_coef_sequencer

Configuration and sequencing controller for the parallel DFE datapath. Fetches the PULSE_RESPONSE_LENGTH packed coefficient words from a synchronous coefficient RAM into a local buffer, resets the DFE and drives its `load_mem`/`location`/`mem_data` load port with the exact beat pattern the DFE requires, waits for `done_wait` under a timeout, then gates the upstream sample stream into the DFE. It sits between the Rx sample source, the coefficient RAM and the DFE instance.

## Interface
- PULSE_RESPONSE_LENGTH, 5, number of coefficient words (2..64)
- SIGNAL_RESOLUTION, 8, sample width
- COEF_AW, 8, coefficient RAM address width
- DFE_RST_CYCLES, 2, length of the DFE reset pulse (>=1)
- DONE_TIMEOUT, 64, cycles allowed from last load beat to `done_wait`
- Reset is `rstn`, asynchronous, active-low; clock is `clk`.
- clk  in  1  clock
- rstn  in  1  async active-low reset
- start  in  1  single-cycle pulse, begin (re)configuration
- coef_base  in  COEF_AW  RAM address of coefficient 0, sampled on accepted `start`
- coef_addr  out  COEF_AW  RAM read address
- coef_rd  out  1  RAM read enable
- coef_rdata  in  64  RAM read data, valid 1 cycle after `coef_rd`
- dfe_rstn  out  1  DFE reset, active-low, registered
- load_mem  out  1  DFE load strobe
- location  out  8  DFE load index
- mem_data  out  64  DFE load data
- done_wait  in  1  DFE load-complete flag
- s_data  in  SIGNAL_RESOLUTION  upstream sample
- s_valid  in  1  upstream valid
- s_ready  out  1  upstream ready
- dfe_signal_in  out  SIGNAL_RESOLUTION  sample to DFE (= `s_data`)
- dfe_signal_in_valid  out  1  `s_valid & s_ready`
- running  out  1  high in RUN
- fault  out  1  sticky timeout flag, cleared by next accepted `start`

## Operation
- States: IDLE, DFE_RST, FETCH, LOAD, WAIT_DONE, RUN, FAULT.
- `start` is accepted in any state. It restarts at DFE_RST, latches `coef_base` and clears `fault`. Any in-flight fetch or load is abandoned.
- DFE_RST:
  - `dfe_rstn`=0 for DFE_RST_CYCLES cycles, then 1, then FETCH.
  - The DFE clears `done_wait` and its load counter only on reset, so every configuration passes through DFE_RST.
- FETCH:
  - Issue `coef_rd` with `coef_addr = coef_base + k` for k = 0..PRL-1 on consecutive cycles.
  - Capture `coef_rdata` one cycle later into buf[k].
  - Address arithmetic wraps modulo 2^COEF_AW.
  - Go to LOAD the cycle after buf[PRL-1] is captured.
- LOAD:
  - The DFE stores `mem_data` at the `location` presented on the previous load beat, and needs PRL+2 beats before `done_wait` rises.
  - Emit exactly PRL+2 consecutive beats j = 0..PRL+1 with `load_mem`=1.
  - Per beat: `location = min(j, PRL-1)`, `mem_data = buf[clamp(j-1, 0, PRL-1)]`.
- WAIT_DONE:
  - `load_mem`=0. A timeout counter starts at 0.
  - `done_wait`=1 goes to RUN.
  - Counter reaching DONE_TIMEOUT with no `done_wait` goes to FAULT and sets `fault`.
- RUN: `s_ready`=1, `running`=1, samples pass through combinationally.
- FAULT: hold until `start`; `s_ready`=0.
- `s_ready`=0 in every state but RUN. `dfe_signal_in_valid` is never high while `load_mem`=1.
- `done_wait` high outside WAIT_DONE is ignored.

## Timing
- Reset values:
  - state IDLE
  - `dfe_rstn`=0 while `rstn` is low, 1 from the first clock after release
  - `load_mem`=0, `location`=0, `mem_data`=0
  - `coef_rd`=0, `coef_addr`=0
  - `s_ready`=0, `running`=0, `fault`=0
- All outputs except `dfe_signal_in`/`dfe_signal_in_valid` are registered.
- `start` at cycle 0 gives:
  - `dfe_rstn` low cycles 1..DFE_RST_CYCLES
  - first `coef_rd` at cycle DFE_RST_CYCLES+1
  - first `load_mem` at cycle DFE_RST_CYCLES+PRL+2
  - last beat PRL+1 cycles later
- `s_ready` rises the cycle after `done_wait` is sampled high in WAIT_DONE.
- `start` in RUN drops `s_ready` the next cycle. A sample accepted in the `start` cycle is still forwarded.
- `rstn` asserted mid-operation: all outputs return to reset values immediately; the buffer contents are don't-care.

## Test plan
- Nominal, PRL=5, DFE model attached:
  - `start` -> 7 load beats, `location` 0,1,2,3,4,4,4, data buf[0],buf[0],buf[1],buf[2],buf[3],buf[4],buf[4]
  - DFE `pulse_response[k]` = RAM[base+k] for all k
  - `running`=1
- Address wrap: `coef_base`=0xFE, PRL=5 -> reads 0xFE,0xFF,0x00,0x01,0x02.
- Timeout: `done_wait` tied 0 -> `fault`=1 exactly DONE_TIMEOUT cycles after the last beat, `s_ready` stays 0; a new `start` clears `fault`.
- Reconfigure in RUN: stream samples, pulse `start` with a new base:
  - `s_ready`=0 next cycle
  - `dfe_rstn` pulse of DFE_RST_CYCLES
  - new coefficients loaded, streaming resumes
  - no `dfe_signal_in_valid` during LOAD
- Restart mid-LOAD: `start` on beat 3 -> beats abort, full sequence restarts from DFE_RST, final DFE contents correct.
- Async reset during FETCH: `rstn` low for 3 cycles -> all outputs at reset values; a later `start` completes normally.
